// File: rtl/comb_pkg.sv
// comb_pkg: shared constants for the comb_test result FIFO.
// Holds the result count, tuple-width rule and default FIFO address width.
package comb_pkg;

  localparam int COMB_NUM_RESULTS = 5;
  localparam int COMB_ADDR_BITS   = 2;

  function automatic int comb_tuple_w(input int size);
    return size * COMB_NUM_RESULTS;
  endfunction

endpackage

// File: rtl/comb_fifo_mem.sv
// comb_fifo_mem: 2**addr_bits x width storage, one write port, async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module comb_fifo_mem #(
  parameter int width     = 5,
  parameter int addr_bits = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addr_bits-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [addr_bits-1:0] raddr,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem_q [2**addr_bits];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/comb_result_fifo.sv
// comb_result_fifo: circular FIFO of comb_test result tuples (out1..out5).
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_r1..5 push
// side; out_valid/out_ready/out_r1..5 head side; count occupancy;
// out_changed head-differs-from-last-pop flag, built only when
// COMB_RESULT_CHANGE_EN is defined (otherwise tied to 0).
module comb_result_fifo
  import comb_pkg::*;
#(
  parameter int size      = 1,
  parameter int addr_bits = COMB_ADDR_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [size-1:0]    in_r1,
  input  logic [size-1:0]    in_r2,
  input  logic [size-1:0]    in_r3,
  input  logic [size-1:0]    in_r4,
  input  logic [size-1:0]    in_r5,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [size-1:0]    out_r1,
  output logic [size-1:0]    out_r2,
  output logic [size-1:0]    out_r3,
  output logic [size-1:0]    out_r4,
  output logic [size-1:0]    out_r5,
  output logic [addr_bits:0] count,
  output logic               out_changed
);

  localparam int TW = comb_tuple_w(size);
  localparam int DEPTH = 2**addr_bits;
  localparam logic [addr_bits:0] DEPTH_C = (addr_bits+1)'(DEPTH);
  localparam logic [addr_bits:0] CNT_ONE = (addr_bits+1)'(1);
  localparam logic [addr_bits-1:0] PTR_ONE = addr_bits'(1);

  logic [addr_bits:0]   count_q, count_d;
  logic [addr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_bits-1:0] rd_ptr_q, rd_ptr_d;
  logic                 push, pop;
  logic [TW-1:0]        wdata, head, head_vis;

  // Full/empty come from count alone; reset gates in_ready directly.
  assign in_ready  = (count_q != DEPTH_C) && !reset;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign wdata = {in_r5, in_r4, in_r3, in_r2, in_r1};

  comb_fifo_mem #(
    .width     (TW),
    .addr_bits (addr_bits)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign head_vis = out_valid ? head : '0;
  assign out_r1 = head_vis[0*size +: size];
  assign out_r2 = head_vis[1*size +: size];
  assign out_r3 = head_vis[2*size +: size];
  assign out_r4 = head_vis[3*size +: size];
  assign out_r5 = head_vis[4*size +: size];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef COMB_RESULT_CHANGE_EN
  logic [TW-1:0] last_popped_q, last_popped_d;
  logic          seen_q, seen_d;

  always_comb begin
    last_popped_d = last_popped_q;
    seen_d        = seen_q;
    if (pop) begin
      last_popped_d = head;
      seen_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_popped_q <= '0;
      seen_q        <= 1'b0;
    end else begin
      last_popped_q <= last_popped_d;
      seen_q        <= seen_d;
    end
  end

  assign out_changed = out_valid && (!seen_q || head != last_popped_q);
`else
  assign out_changed = 1'b0;
`endif

endmodule
